btb_train_gen: RTL

Commit-side training source for the branch target buffer. Captures every resolved conditional branch and indirect jump from the branch execution unit, holds it in an in-order queue until the reorder buffer retires it, and then issues exactly one single-cycle training event with active-low strobes (`br_commit_`, `br_taken_`, `br_miss_`, `jump_commit_`, `jump_miss_`, `com_addr`, `com_tar_addr`) to the BTB. Sits between the branch unit / ROB commit stage and the BTB, so no speculative or flushed branch ever trains the predictor.

---
 rtl/btb_train_gen.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/btb_train_gen.sv
// Commit-side BTB training source: queues resolved branches/jumps in order and
// emits one registered, active-low training event per ROB retire.
module btb_train_gen #(
   parameter int ADDR = 32,
   parameter int TQ_D = 8
) (
   input  logic                    clk,
   input  logic                    reset_,
   input  logic                    ex_valid_,
   input  logic                    ex_jump,
   input  logic [ADDR-1:0]         ex_pc,
   input  logic                    ex_taken,
   input  logic [ADDR-1:0]         ex_target,
   input  logic                    ex_pred_hit,
   input  logic [ADDR-1:0]         ex_pred_addr,
   output logic                    tq_full,
   input  logic                    com_br_,
   input  logic                    flush_,
   output logic                    br_commit_,
   output logic                    br_taken_,
   output logic                    br_miss_,
   output logic                    jump_commit_,
   output logic                    jump_miss_,
   output logic [ADDR-1:0]         com_addr,
   output logic [ADDR-1:0]         com_tar_addr,
   output logic [$clog2(TQ_D):0]   tq_cnt,
   output logic                    tq_err
);

   localparam int PW = $clog2(TQ_D);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH = CW'(TQ_D);

   logic [ADDR-1:0] pc_mem_q  [TQ_D];
   logic [ADDR-1:0] tar_mem_q [TQ_D];
   logic            tk_mem_q  [TQ_D];
   logic            ms_mem_q  [TQ_D];
   logic            jp_mem_q  [TQ_D];

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            br_commit_q, br_commit_d;
   logic            br_taken_q, br_taken_d;
   logic            br_miss_q, br_miss_d;
   logic            jump_commit_q, jump_commit_d;
   logic            jump_miss_q, jump_miss_d;
   logic [ADDR-1:0] com_addr_q, com_addr_d;
   logic [ADDR-1:0] com_tar_q, com_tar_d;

   logic full, empty, pop, push_req, push, ex_miss;

   always_comb begin
      full     = (cnt_q == DEPTH);
      empty    = (cnt_q == '0);
      pop      = !com_br_ && !empty;
      push_req = !ex_valid_;
      // a retire in the same cycle frees the slot the push needs when full
      push     = push_req && flush_ && (!full || pop);

      if (ex_jump)
         ex_miss = !ex_pred_hit || (ex_target != ex_pred_addr);
      else
         ex_miss = (ex_taken != ex_pred_hit) ||
                   (ex_taken && ex_pred_hit && (ex_target != ex_pred_addr));

      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

      if (!flush_)
         wr_ptr_d = rd_ptr_d;
      else if (push)
         wr_ptr_d = wr_ptr_q + PW'(1);
      else
         wr_ptr_d = wr_ptr_q;

      if (!flush_)
         cnt_d = '0;
      else if (push && !pop)
         cnt_d = cnt_q + CW'(1);
      else if (pop && !push)
         cnt_d = cnt_q - CW'(1);
      else
         cnt_d = cnt_q;

      err_d = err_q || (push_req && full && !pop) || (!com_br_ && empty);

      br_commit_d   = 1'b1;
      br_taken_d    = 1'b1;
      br_miss_d     = 1'b1;
      jump_commit_d = 1'b1;
      jump_miss_d   = 1'b1;
      com_addr_d    = com_addr_q;
      com_tar_d     = com_tar_q;
      if (pop) begin
         com_addr_d = pc_mem_q[rd_ptr_q];
         com_tar_d  = tar_mem_q[rd_ptr_q];
         if (jp_mem_q[rd_ptr_q]) begin
            jump_commit_d = 1'b0;
            jump_miss_d   = !ms_mem_q[rd_ptr_q];
         end else begin
            br_commit_d = 1'b0;
            br_taken_d  = !tk_mem_q[rd_ptr_q];
            br_miss_d   = !ms_mem_q[rd_ptr_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         cnt_q         <= '0;
         err_q         <= 1'b0;
         br_commit_q   <= 1'b1;
         br_taken_q    <= 1'b1;
         br_miss_q     <= 1'b1;
         jump_commit_q <= 1'b1;
         jump_miss_q   <= 1'b1;
         com_addr_q    <= '0;
         com_tar_q     <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         cnt_q         <= cnt_d;
         err_q         <= err_d;
         br_commit_q   <= br_commit_d;
         br_taken_q    <= br_taken_d;
         br_miss_q     <= br_miss_d;
         jump_commit_q <= jump_commit_d;
         jump_miss_q   <= jump_miss_d;
         com_addr_q    <= com_addr_d;
         com_tar_q     <= com_tar_d;
      end
   end

   // entry storage needs no reset; validity is tracked by the pointers
   always_ff @(posedge clk) begin
      if (reset_ && push) begin
         pc_mem_q[wr_ptr_q]  <= ex_pc;
         tar_mem_q[wr_ptr_q] <= ex_target;
         tk_mem_q[wr_ptr_q]  <= ex_taken;
         ms_mem_q[wr_ptr_q]  <= ex_miss;
         jp_mem_q[wr_ptr_q]  <= ex_jump;
      end
   end

   assign tq_full      = (cnt_q == DEPTH);
   assign tq_cnt       = cnt_q;
   assign tq_err       = err_q;
   assign br_commit_   = br_commit_q;
   assign br_taken_    = br_taken_q;
   assign br_miss_     = br_miss_q;
   assign jump_commit_ = jump_commit_q;
   assign jump_miss_   = jump_miss_q;
   assign com_addr     = com_addr_q;
   assign com_tar_addr = com_tar_q;

endmodule
